aes_stream_host: RTL and testbench
==================================

# aes_stream_host

Bus-initiator engine that drives the `aes_block` register port on behalf of a streaming client. It accepts a 128-bit block on a valid/ready input and writes it into `aes_block` as four 32-bit words. It then starts one encryption, waits for `aes_block`'s `INT`, reads back the four result words, and presents the 128-bit result on a valid/ready output. It sits between a data mover (or the MIPS MMIO path) and `aes_block`. The key is loaded separately by software and is not this block's concern.

## Interface

Parameters:
- `ADDR_CTRL`, 8'h08: `aes_block` control register address; writing `CTRL_NEXT` starts one block.
- `CTRL_NEXT`, 32'h0000_0002: value written to `ADDR_CTRL` to start.
- `ADDR_BLOCK`, 8'h10: base of the four input-word registers (word k at `ADDR_BLOCK`+k).
- `ADDR_RESULT`, 8'h30: base of the four result-word registers.
- `TIMEOUT`, 1024: maximum cycles to wait for `aes_int`; 16-bit counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `in_block` is valid.
- `in_ready`, out, 1: engine can accept a block.
- `in_block`, in, 128: plaintext; [127:96] is word 0.
- `out_valid`, out, 1: `out_block` is valid.
- `out_ready`, in, 1: consumer accepts `out_block`.
- `out_block`, out, 128: result; [127:96] is word 0.
- `busy`, out, 1: high in every state except IDLE.
- `err`, out, 1: sticky timeout flag; cleared by the next accepted input.
- `aes_cs`, out, 1: `aes_block` chip select.
- `aes_we`, out, 1: write strobe, qualified by `aes_cs`.
- `aes_address`, out, 8: register address.
- `aes_wdata`, out, 32: to `aes_block` `write_block`.
- `aes_rdata`, in, 32: from `aes_block` `read_block`; valid the cycle after a read strobe.
- `aes_int`, in, 1: `aes_block` completion, level; cleared by `aes_block` on result read.

## Operation

States are IDLE, WR, START, WAIT, RD, OUT.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, capture `in_block` into a 128-bit register, clear `err`, set idx=0, and go to WR.
- WR: drive `aes_cs`=1, `aes_we`=1, `aes_address`=`ADDR_BLOCK`+idx, `aes_wdata`=word idx. idx increments each cycle; after idx=3, go to START.
- START: one cycle with `aes_cs`=1, `aes_we`=1, `aes_address`=`ADDR_CTRL`, `aes_wdata`=`CTRL_NEXT`. Clear the timeout counter and go to WAIT.
- WAIT: `aes_cs`=0. If `aes_int`=1, set idx=0 and go to RD. Else increment the counter; when it reaches `TIMEOUT`-1, set `err`=1 and go to IDLE with no output.
- RD: drive `aes_cs`=1, `aes_we`=0, `aes_address`=`ADDR_RESULT`+idx for idx 0..3 on consecutive cycles. `aes_rdata` is captured one cycle later into word idx-1 of the result register. After the capture of word 3 (the cycle after the last strobe, with `aes_cs`=0), go to OUT.
- OUT: `out_valid`=1 and `out_block` held stable until `out_ready`, then go to IDLE.
- `aes_int` arriving in any state other than WAIT is ignored.
- `aes_wdata` and `aes_address` are don't-care when `aes_cs`=0, but are driven to 0 for determinism.
- All `aes_*` outputs are registered from state, with no combinational path from inputs.

## Timing

- Reset values (asynchronous, on `reset_n`=0): state=IDLE; `in_ready`=1; `out_valid`=0; `out_block`=0; `busy`=0; `err`=0; `aes_cs`=0; `aes_we`=0; `aes_address`=0; `aes_wdata`=0; idx=0; counter=0.
- Accept at edge t: WR strobes at t+1..t+4, START at t+5, WAIT from t+6.
- `aes_int` seen at edge w: RD strobes w+1..w+4, last capture w+5, `out_valid` from w+6.
- Minimum input-to-output latency is 12 cycles plus the AES core time.
- Throughput is one block in flight. `in_ready`=0 from the accept edge until the return to IDLE.
- `out_valid`&`out_ready` at edge o: IDLE at o+1, so the next accept is possible at o+1.
- `reset_n` asserted mid-operation aborts immediately and discards all data. `aes_block` is reset by the same `reset_n`.
- `in_valid` may drop while `in_ready`=0 with no effect.

## Structure

- Shared package `aes_host_pkg`:
  - state enum;
  - default register addresses and `CTRL_NEXT`;
  - word-index macro mapping k to bits [127-32k -: 32].
- One natural sub-module, `aes_host_timer`: a 16-bit clear/enable counter with a terminal-count output, reusable by other MMIO initiators.
- The FSM and the data registers live in the top module.

## Test plan

- **FIPS-197 vector:** bench preloads key 000102030405060708090a0b0c0d0e0f into `aes_block`; input 00112233445566778899aabbccddeeff -> `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a; write strobes to addresses 10,11,12,13,08 in that order.
- **Back-to-back:** two blocks with `out_ready` tied high -> second `in_ready` rises exactly one cycle after first `out_valid`; both results are correct.
- **Output backpressure:** `out_ready`=0 for 20 cycles in OUT -> `out_block` is stable, `in_ready`=0, and no `aes_cs` activity.
- **Timeout:** `aes_int` forced low with `TIMEOUT`=16 -> `err`=1 exactly 16 cycles after START, state returns to IDLE, `out_valid` never rises; the next accepted block clears `err`.
- **Reset mid-RD:** `reset_n` pulsed low during the second read strobe -> all outputs are at their reset values immediately, and `aes_cs`=0 asynchronously.
- **Spurious interrupt:** `aes_int` pulse during WR -> ignored; the sequence completes with the correct result.

Source files
------------

// File: rtl/aes_host_pkg.sv
// aes_host_pkg: shared types and defaults for the aes_block stream host.
// Holds the FSM state enum, default register map and a word selector.
package aes_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_START,
        S_WAIT,
        S_RD,
        S_OUT
    } state_t;

    localparam logic [7:0]  ADDR_CTRL_DEF   = 8'h08;
    localparam logic [31:0] CTRL_NEXT_DEF   = 32'h0000_0002;
    localparam logic [7:0]  ADDR_BLOCK_DEF  = 8'h10;
    localparam logic [7:0]  ADDR_RESULT_DEF = 8'h30;

    // Word k of a block; word 0 is the most significant.
    function automatic logic [31:0] word_of(
        input logic [127:0] blk,
        input logic [1:0]   k
    );
        return blk[127 - 32 * int'(k) -: 32];
    endfunction

endpackage

// File: rtl/aes_stream_host_if.sv
// aes_stream_host_if: input stream, output stream and aes_block bus.
// master = the host engine, slave = client, consumer and aes_block.
interface aes_stream_host_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         aes_cs;
    logic         aes_we;
    logic [7:0]   aes_address;
    logic [31:0]  aes_wdata;
    logic [31:0]  aes_rdata;
    logic         aes_int;

    modport master (
        input  in_valid, in_block, out_ready, aes_rdata, aes_int,
        output in_ready, out_valid, out_block,
        output aes_cs, aes_we, aes_address, aes_wdata
    );

    modport slave (
        output in_valid, in_block, out_ready, aes_rdata, aes_int,
        input  in_ready, out_valid, out_block,
        input  aes_cs, aes_we, aes_address, aes_wdata
    );

endinterface

// File: rtl/aes_host_timer.sv
// aes_host_timer: 16-bit clear/enable counter with terminal count.
// Ports: clk, reset_n, i_clr (sync clear), i_en (count), o_tc (at LIMIT-1).
module aes_host_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [15:0] TC = 16'(LIMIT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/aes_stream_host.sv
// aes_stream_host: writes a 128-bit block into aes_block, starts it,
// waits for aes_int, reads the result back and streams it out.
// Ports: clk, reset_n (async, active low), bus (streams + aes_block
// master port), busy (not idle), err (sticky timeout, cleared on accept).
module aes_stream_host
    import aes_host_pkg::*;
#(
    parameter logic [7:0]  ADDR_CTRL   = ADDR_CTRL_DEF,
    parameter logic [31:0] CTRL_NEXT   = CTRL_NEXT_DEF,
    parameter logic [7:0]  ADDR_BLOCK  = ADDR_BLOCK_DEF,
    parameter logic [7:0]  ADDR_RESULT = ADDR_RESULT_DEF,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    aes_stream_host_if.master bus,
    output logic              busy,
    output logic              err
);

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_idx;
    logic [2:0]   w_idx;
    logic [127:0] r_in;
    logic [127:0] r_res;
    logic [127:0] w_src;
    logic         r_err;
    logic         r_cs;
    logic         r_we;
    logic [7:0]   r_addr;
    logic [31:0]  r_wdata;
    logic         w_cs;
    logic         w_we;
    logic [7:0]   w_addr;
    logic [31:0]  w_wdata;
    logic         w_accept;
    logic         w_tmr_clr;
    logic         w_tmr_en;
    logic         w_tmr_tc;
    logic         w_timeout;

    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
    assign w_tmr_clr = (r_state == S_START);
    assign w_tmr_en  = (r_state == S_WAIT) && !bus.aes_int;
    assign w_timeout = w_tmr_en && w_tmr_tc;

    // Word 0 goes out on the accept edge, before r_in holds the block.
    assign w_src = (r_state == S_IDLE) ? bus.in_block : r_in;

    aes_host_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_tc    (w_tmr_tc)
    );

    // State and bus registers move together, so the bus shows the
    // strobe belonging to the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx;
            r_cs    <= w_cs;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        w_idx  = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_WR;
                    w_idx  = '0;
                end
            end
            S_WR: begin
                if (r_idx == 3'd3) begin
                    w_next = S_START;
                    w_idx  = '0;
                end else begin
                    w_idx = r_idx + 3'd1;
                end
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.aes_int) begin
                    w_next = S_RD;
                    w_idx  = '0;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            // idx 4 is the bus-idle cycle that captures the last word.
            S_RD: begin
                if (r_idx == 3'd4) begin
                    w_next = S_OUT;
                    w_idx  = '0;
                end else begin
                    w_idx = r_idx + 3'd1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cs    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        unique case (w_next)
            S_WR: begin
                w_cs    = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_BLOCK + {5'd0, w_idx};
                w_wdata = word_of(w_src, w_idx[1:0]);
            end
            S_START: begin
                w_cs    = 1'b1;
                w_we    = 1'b1;
                w_addr  = ADDR_CTRL;
                w_wdata = CTRL_NEXT;
            end
            S_RD: begin
                if (w_idx != 3'd4) begin
                    w_cs   = 1'b1;
                    w_addr = ADDR_RESULT + {5'd0, w_idx};
                end
            end
            default: begin
                w_cs = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in  <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in  <= bus.in_block;
                r_err <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // aes_rdata lags its strobe by one cycle: word idx-1.
            if (r_state == S_RD) begin
                case (r_idx)
                    3'd1:    r_res[127:96] <= bus.aes_rdata;
                    3'd2:    r_res[95:64]  <= bus.aes_rdata;
                    3'd3:    r_res[63:32]  <= bus.aes_rdata;
                    3'd4:    r_res[31:0]   <= bus.aes_rdata;
                    default: r_res         <= r_res;
                endcase
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.out_block   = r_res;
    assign bus.aes_cs      = r_cs;
    assign bus.aes_we      = r_we;
    assign bus.aes_address = r_addr;
    assign bus.aes_wdata   = r_wdata;
    assign busy            = (r_state != S_IDLE);
    assign err             = r_err;

endmodule

// File: tb/tb_aes_stream_host.sv
// tb_aes_stream_host: drives aes_stream_host against a behavioural
// aes_block (real AES-128) and checks results, timing and bus traffic.
module tb_aes_stream_host;

    logic clk;
    logic reset_n;
    logic busy;
    logic err;

    aes_stream_host_if bus ();

    aes_stream_host #(
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .err     (err)
    );

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- AES-128 reference ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h01;
            if (v == 0) inv = 8'h00;
            else for (int e = 0; e < 254; e++) inv = gmul(inv, x);
            sb[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        st = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[st[127 - 8 * i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[4*c+j] = s[4*((c+j)%4)+j];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[127 - 8 * i -: 8] = t[i];
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return st;
    endfunction

    // ---------------- aes_block model ----------------
    logic [127:0] key;
    int           lat;
    logic         int_kill;
    logic         int_spur;
    logic [31:0]  m_blk [4];
    logic [127:0] m_res;
    logic         m_busy;
    logic         m_int;
    int           m_cnt;
    logic [31:0]  m_rdata;
    logic [39:0]  wr_log [$];

    assign bus.aes_int   = (m_int & ~int_kill) | int_spur;
    assign bus.aes_rdata = m_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy  <= 1'b0;
            m_int   <= 1'b0;
            m_cnt   <= 0;
            m_rdata <= '0;
        end else begin
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_int  <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (bus.aes_cs && bus.aes_we) begin
                wr_log.push_back({bus.aes_address, bus.aes_wdata});
                if (bus.aes_address[7:2] == 6'h04)
                    m_blk[bus.aes_address[1:0]] <= bus.aes_wdata;
                if (bus.aes_address == 8'h08 && bus.aes_wdata == 32'h2) begin
                    m_res  <= aes128(key, {m_blk[0], m_blk[1], m_blk[2], m_blk[3]});
                    m_busy <= 1'b1;
                    m_cnt  <= lat;
                    m_int  <= 1'b0;
                end
            end
            if (bus.aes_cs && !bus.aes_we) begin
                m_int <= 1'b0;
                if (bus.aes_address[7:2] == 6'h0c)
                    m_rdata <= m_res[127 - 32 * int'(bus.aes_address[1:0]) -: 32];
                else
                    m_rdata <= '0;
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present b until accepted; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] b, output bit ok);
        int n;
        n = 0;
        bus.in_block = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Collect one result; n counts negedges waited for out_valid.
    task automatic recv(output logic [127:0] b, output int n);
        n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        b = bus.out_block;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL reset_flags: rdy=%b ov=%b busy=%b err=%b, want 1 0 0 0",
                bus.in_ready, bus.out_valid, busy, err); end
        checks++;
        if (bus.out_block !== 128'h0)
            begin errors++; $display("FAIL reset_out_block: got %h want 0", bus.out_block); end
        checks++;
        if (bus.aes_cs !== 1'b0 || bus.aes_we !== 1'b0 || bus.aes_address !== 8'h00 || bus.aes_wdata !== 32'h0)
            begin errors++; $display("FAIL reset_bus: cs=%b we=%b a=%h d=%h, want all 0",
                bus.aes_cs, bus.aes_we, bus.aes_address, bus.aes_wdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.aes_cs !== 1'b0)
            begin errors++; $display("FAIL reset_idle: rdy=%b busy=%b cs=%b, want 1 0 0",
                bus.in_ready, busy, bus.aes_cs); end
    endtask

    task automatic test_fips();
        logic [127:0] pt;
        logic [127:0] got;
        logic [39:0]  e [5];
        int           n;
        bit           ok;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        pt  = 128'h00112233445566778899aabbccddeeff;
        lat = 3;
        wr_log.delete();
        send(pt, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fips_accept: in_ready never seen"); end
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL fips_busy: rdy=%b busy=%b, want 0 1", bus.in_ready, busy); end
        recv(got, n);
        checks++;
        if (got !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
            begin errors++; $display("FAIL fips_result: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", got); end
        checks++;
        if (n !== lat + 12)
            begin errors++; $display("FAIL fips_latency: got %0d want %0d", n, lat + 12); end
        e[0] = {8'h10, pt[127:96]};
        e[1] = {8'h11, pt[95:64]};
        e[2] = {8'h12, pt[63:32]};
        e[3] = {8'h13, pt[31:0]};
        e[4] = {8'h08, 32'h2};
        checks++;
        if (wr_log.size() != 5)
            begin errors++; $display("FAIL fips_wr_count: got %0d want 5", wr_log.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (wr_log[i] !== e[i])
                begin errors++; $display("FAIL fips_wr%0d: got %h want %h", i, wr_log[i], e[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b0, b1, got;
        int           n;
        bit           ok;
        b0  = rnd128();
        b1  = rnd128();
        lat = int'($urandom_range(0, 6));
        bus.out_ready = 1'b1;
        send(b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_accept0: in_ready never seen"); end
        bus.in_block = b1;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        got = bus.out_block;
        checks++;
        if (got !== aes128(key, b0))
            begin errors++; $display("FAIL b2b_result0: got %h want %h", got, aes128(key, b0)); end
        checks++;
        if (bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL b2b_ready_early: rdy=%b want 0 with out_valid", bus.in_ready); end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_ready_next: rdy=%b ov=%b want 1 0", bus.in_ready, bus.out_valid); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL b2b_accept1: rdy=%b want 0", bus.in_ready); end
        recv(got, n);
        checks++;
        if (got !== aes128(key, b1) || n >= 100)
            begin errors++; $display("FAIL b2b_result1: got %h want %h", got, aes128(key, b1)); end
    endtask

    task automatic test_backpressure();
        logic [127:0] b, got;
        int           n;
        bit           ok;
        bit           bad;
        b   = rnd128();
        lat = int'($urandom_range(0, 8));
        bus.out_ready = 1'b0;
        send(b, ok);
        n = 0;
        while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
        got = bus.out_block;
        checks++;
        if (!ok || got !== aes128(key, b))
            begin errors++; $display("FAIL bp_result: got %h want %h", got, aes128(key, b)); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_block !== got || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.aes_cs !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL bp_hold: out=%h ov=%b rdy=%b cs=%b want %h 1 0 0",
            bus.out_block, bus.out_valid, bus.in_ready, bus.aes_cs, got); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release: ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_timeout();
        logic [127:0] b, got;
        int           n;
        bit           ok;
        bit           early;
        bit           ov_seen;
        b   = rnd128();
        lat = 2;
        int_kill = 1'b1;
        send(b, ok);
        n = 0;
        while (!(bus.aes_cs && bus.aes_we && bus.aes_address == 8'h08) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL to_start: START strobe not seen"); end
        early = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (err !== 1'b0) early = 1'b1;
            if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL to_early: err=1 before 16 cycles, want 0"); end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL to_err: err=%b rdy=%b busy=%b want 1 1 0", err, bus.in_ready, busy); end
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
        end
        checks++;
        if (ov_seen) begin errors++; $display("FAIL to_out_valid: out_valid=1 want 0"); end
        int_kill = 1'b0;
        b = rnd128();
        send(b, ok);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: err=%b want 0", err); end
        recv(got, n);
        checks++;
        if (got !== aes128(key, b) || n >= 100)
            begin errors++; $display("FAIL to_recover: got %h want %h", got, aes128(key, b)); end
    endtask

    task automatic test_reset_mid_rd();
        logic [127:0] b;
        int           n;
        bit           ok;
        b   = rnd128();
        lat = int'($urandom_range(0, 8));
        send(b, ok);
        n = 0;
        while (!(bus.aes_cs && !bus.aes_we && bus.aes_address == 8'h31) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL rst_rd_seen: second read strobe not seen"); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.aes_cs !== 1'b0 || bus.aes_we !== 1'b0 || bus.aes_address !== 8'h00 || bus.aes_wdata !== 32'h0)
            begin errors++; $display("FAIL rst_rd_bus: cs=%b we=%b a=%h d=%h want all 0",
                bus.aes_cs, bus.aes_we, bus.aes_address, bus.aes_wdata); end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL rst_rd_flags: rdy=%b ov=%b busy=%b err=%b want 1 0 0 0",
                bus.in_ready, bus.out_valid, busy, err); end
        checks++;
        if (bus.out_block !== 128'h0)
            begin errors++; $display("FAIL rst_rd_out_block: got %h want 0", bus.out_block); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [127:0] b, got;
        int           n;
        bit           ok;
        b   = rnd128();
        lat = int'($urandom_range(0, 8));
        send(b, ok);
        int_spur = 1'b1;
        @(negedge clk);
        int_spur = 1'b0;
        recv(got, n);
        checks++;
        if (!ok || got !== aes128(key, b))
            begin errors++; $display("FAIL spur_result: got %h want %h", got, aes128(key, b)); end
        checks++;
        if (n !== lat + 11)
            begin errors++; $display("FAIL spur_latency: got %0d want %0d", n, lat + 11); end
    endtask

    task automatic test_random();
        logic [127:0] b, got;
        int           n;
        bit           ok;
        for (int i = 0; i < 6; i++) begin
            key = rnd128();
            b   = rnd128();
            lat = int'($urandom_range(0, 8));
            send(b, ok);
            recv(got, n);
            checks++;
            if (!ok || got !== aes128(key, b))
                begin errors++; $display("FAIL rand%0d_result: got %h want %h", i, got, aes128(key, b)); end
            checks++;
            if (n !== lat + 12)
                begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, n, lat + 12); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.out_ready = 1'b0;
        int_kill = 1'b0;
        int_spur = 1'b0;
        lat = 0;
        key = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid_rd();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
